// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for alu_cmd_seq: ALU op codes, command funct codes, FSM states.
// Optional feature macro: ALU_SEQ_ILLEGAL_EN (illegal-funct error reporting).
package alu_cmd_seq_pkg;

  localparam logic [2:0] ALUOP_OR   = 3'd0;
  localparam logic [2:0] ALUOP_AND  = 3'd1;
  localparam logic [2:0] ALUOP_XOR  = 3'd2;
  localparam logic [2:0] ALUOP_ADD  = 3'd3;
  localparam logic [2:0] ALUOP_NOR  = 3'd4;
  localparam logic [2:0] ALUOP_NAND = 3'd5;
  localparam logic [2:0] ALUOP_SLT  = 3'd6;
  localparam logic [2:0] ALUOP_SUB  = 3'd7;

  // Codes 8-15 have funct[3] set and are illegal when checking is enabled.
  localparam logic [3:0] FUNCT_OR   = 4'd0;
  localparam logic [3:0] FUNCT_AND  = 4'd1;
  localparam logic [3:0] FUNCT_XOR  = 4'd2;
  localparam logic [3:0] FUNCT_ADD  = 4'd3;
  localparam logic [3:0] FUNCT_NOR  = 4'd4;
  localparam logic [3:0] FUNCT_NAND = 4'd5;
  localparam logic [3:0] FUNCT_SLT  = 4'd6;
  localparam logic [3:0] FUNCT_SUB  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_cmd_seq_alu_op_decode.sv
// Combinational funct -> ALU op decoder with illegal-code flag.
// Illegal detection on funct[3] exists only when ALU_SEQ_ILLEGAL_EN is defined.
module alu_op_decode
  import alu_cmd_seq_pkg::*;
(
  input  logic [3:0] funct,
  output logic [2:0] aluop,
  output logic       illegal
);

  // Map the low three funct bits onto the ALU operation select.
  always_comb begin
    aluop = ALUOP_OR;
    case (funct[2:0])
      FUNCT_OR[2:0]:   aluop = ALUOP_OR;
      FUNCT_AND[2:0]:  aluop = ALUOP_AND;
      FUNCT_XOR[2:0]:  aluop = ALUOP_XOR;
      FUNCT_ADD[2:0]:  aluop = ALUOP_ADD;
      FUNCT_NOR[2:0]:  aluop = ALUOP_NOR;
      FUNCT_NAND[2:0]: aluop = ALUOP_NAND;
      FUNCT_SLT[2:0]:  aluop = ALUOP_SLT;
      FUNCT_SUB[2:0]:  aluop = ALUOP_SUB;
      default:         aluop = ALUOP_OR;
    endcase
  end

`ifdef ALU_SEQ_ILLEGAL_EN
  assign illegal = funct[3];
`else
  logic unused_funct_msb_s;
  assign unused_funct_msb_s = funct[3];
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: IDLE -> READ -> EXEC -> WB around an external combinational ALU,
// with a local register file. Optional macro ALU_SEQ_ILLEGAL_EN adds the err pulse.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_funct,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic              cmd_use_imm,
  input  logic [31:0]       cmd_imm,
  output logic [31:0]       alu_op1,
  output logic [31:0]       alu_op2,
  output logic [2:0]        alu_aluop,
  input  logic [31:0]       alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [31:0]       wb_data
`ifdef ALU_SEQ_ILLEGAL_EN
  ,
  output logic              err
`endif
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] RZERO = {REG_AW{1'b0}};

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [3:0]        funct_q, funct_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              use_imm_q, use_imm_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [2:0]        alu_aluop_q, alu_aluop_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [31:0]       rf_q [NREG];
  logic [31:0]       rf_d [NREG];
  logic [2:0]        dec_aluop_s;
  logic              dec_illegal_s;
  logic              accept_s;
  logic [31:0]       rs1_val_s, rs2_val_s;

  alu_op_decode u_dec (
    .funct   (funct_q),
    .aluop   (dec_aluop_s),
    .illegal (dec_illegal_s)
  );

  assign accept_s  = cmd_valid & cmd_ready_q;
  assign rs1_val_s = (rs1_q == RZERO) ? 32'd0 : rf_q[rs1_q];
  assign rs2_val_s = (rs2_q == RZERO) ? 32'd0 : rf_q[rs2_q];

  // Next-state, capture, operand latch and writeback computation.
  always_comb begin
    state_d     = state_q;
    funct_d     = funct_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    use_imm_d   = use_imm_q;
    imm_d       = imm_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_aluop_d = alu_aluop_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    rf_d        = rf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          funct_d   = cmd_funct;
          rs1_d     = cmd_rs1;
          rs2_d     = cmd_rs2;
          rd_d      = cmd_rd;
          use_imm_d = cmd_use_imm;
          imm_d     = cmd_imm;
          state_d   = ST_READ;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_READ: begin
        alu_op1_d   = rs1_val_s;
        alu_op2_d   = use_imm_q ? imm_q : rs2_val_s;
        alu_aluop_d = dec_aluop_s;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WB;
        // The RF write lands on the same edge that raises wb_valid, so a
        // following command's READ already sees the new value.
        if (dec_illegal_s) begin
          err_d = 1'b1;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = alu_result;
          if (rd_q != RZERO) begin
            rf_d[rd_q] = alu_result;
          end else begin
            rf_d[0] = 32'd0;
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      funct_q     <= 4'd0;
      rs1_q       <= RZERO;
      rs2_q       <= RZERO;
      rd_q        <= RZERO;
      use_imm_q   <= 1'b0;
      imm_q       <= 32'd0;
      alu_op1_q   <= 32'd0;
      alu_op2_q   <= 32'd0;
      alu_aluop_q <= 3'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= RZERO;
      wb_data_q   <= 32'd0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      funct_q     <= funct_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      use_imm_q   <= use_imm_d;
      imm_q       <= imm_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_aluop_q <= alu_aluop_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      rf_q        <= rf_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_aluop = alu_aluop_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
`ifdef ALU_SEQ_ILLEGAL_EN
  assign err       = err_q;
`else
  logic unused_err_s;
  assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq with a behavioural ALU attached.
// Define ALU_SEQ_ILLEGAL_EN to also exercise the err pulse.
module tb_alu_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_funct;
  logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic        cmd_use_imm;
  logic [31:0] cmd_imm;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_aluop;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef ALU_SEQ_ILLEGAL_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_cmd_seq #(.REG_AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_funct   (cmd_funct),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_aluop   (alu_aluop),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
`ifdef ALU_SEQ_ILLEGAL_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  // External ALU model.
  always_comb begin
    case (alu_aluop)
      3'd0:    alu_result = alu_op1 | alu_op2;
      3'd1:    alu_result = alu_op1 & alu_op2;
      3'd2:    alu_result = alu_op1 ^ alu_op2;
      3'd3:    alu_result = alu_op1 + alu_op2;
      3'd4:    alu_result = ~(alu_op1 | alu_op2);
      3'd5:    alu_result = ~(alu_op1 & alu_op2);
      3'd6:    alu_result = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      3'd7:    alu_result = alu_op1 - alu_op2;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (cmd_ready !== 1'b1) check_val("ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [3:0] f, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [2:0] rd, input logic ui,
                        input logic [31:0] imm, input logic [31:0] e_op1,
                        input logic [31:0] e_op2, input logic [2:0] e_aluop,
                        input logic [31:0] e_data, input logic e_wb);
    wait_ready();
    cmd_valid = 1'b1; cmd_funct = f; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_rd = rd; cmd_use_imm = ui; cmd_imm = imm;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured command must be unaffected.
    cmd_valid = 1'b0; cmd_funct = f ^ 4'd5; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2;
    cmd_rd = ~rd; cmd_use_imm = ~ui; cmd_imm = ~imm;
    @(negedge clk);
    check_val({tag, "_read_wbv"}, {31'd0, wb_valid}, 32'd0);
    check_val({tag, "_read_rdy"}, {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_val({tag, "_op1"}, alu_op1, e_op1);
    check_val({tag, "_op2"}, alu_op2, e_op2);
    check_val({tag, "_aluop"}, {29'd0, alu_aluop}, {29'd0, e_aluop});
    @(negedge clk);
    check_val({tag, "_wbv"}, {31'd0, wb_valid}, {31'd0, e_wb});
    if (e_wb) begin
      check_val({tag, "_wbrd"}, {29'd0, wb_rd}, {29'd0, rd});
      check_val({tag, "_wbdata"}, wb_data, e_data);
    end
`ifdef ALU_SEQ_ILLEGAL_EN
    check_val({tag, "_err"}, {31'd0, err}, {31'd0, f[3]});
`endif
    @(negedge clk);
    check_val({tag, "_wbv_pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pattern;
    int         n_acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_funct = 4'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_rd = 3'd0; cmd_use_imm = 1'b0; cmd_imm = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_val("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check_val("rst_wbdata", wb_data, 32'd0);
    check_val("rst_op1", alu_op1, 32'd0);
    check_val("rst_aluop", {29'd0, alu_aluop}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    //      tag       f      rs1   rs2   rd    ui    imm            op1            op2            aluop data           wb
    do_cmd("add1",  4'd3, 3'd0, 3'd0, 3'd1, 1'b1, 32'd5,         32'd0,         32'd5,         3'd3, 32'd5,         1'b1);
    do_cmd("sub2",  4'd7, 3'd1, 3'd0, 3'd2, 1'b1, 32'd7,         32'd5,         32'd7,         3'd7, 32'hFFFFFFFE,  1'b1);
    do_cmd("or3",   4'd0, 3'd2, 3'd0, 3'd3, 1'b1, 32'd0,         32'hFFFFFFFE,  32'd0,         3'd0, 32'hFFFFFFFE,  1'b1);
    do_cmd("slt4",  4'd6, 3'd1, 3'd0, 3'd4, 1'b1, 32'hFFFFFFFF,  32'd5,         32'hFFFFFFFF,  3'd6, 32'd1,         1'b1);
    do_cmd("xor5",  4'd2, 3'd2, 3'd1, 3'd5, 1'b0, 32'd12345,     32'hFFFFFFFE,  32'd5,         3'd2, 32'hFFFFFFFB,  1'b1);
    do_cmd("add6",  4'd3, 3'd1, 3'd0, 3'd6, 1'b1, 32'd1,         32'd5,         32'd1,         3'd3, 32'd6,         1'b1);
    do_cmd("nand7", 4'd5, 3'd6, 3'd6, 3'd7, 1'b0, 32'd0,         32'd6,         32'd6,         3'd5, 32'hFFFFFFF9,  1'b1);
    do_cmd("nor3",  4'd4, 3'd0, 3'd0, 3'd3, 1'b1, 32'd0,         32'd0,         32'd0,         3'd4, 32'hFFFFFFFF,  1'b1);
    do_cmd("wrap5", 4'd3, 3'd3, 3'd0, 3'd5, 1'b1, 32'd2,         32'hFFFFFFFF,  32'd2,         3'd3, 32'd1,         1'b1);
    do_cmd("add0",  4'd3, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9,         32'd0,         32'd9,         3'd3, 32'd9,         1'b1);
    do_cmd("rd_r0", 4'd0, 3'd0, 3'd0, 3'd2, 1'b0, 32'd55,        32'd0,         32'd0,         3'd0, 32'd0,         1'b1);

    // cmd_valid held high for 8 cycles: acceptances every 4 cycles.
    wait_ready();
    cmd_valid = 1'b1; cmd_funct = 4'd3; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_rd = 3'd4; cmd_use_imm = 1'b1; cmd_imm = 32'd3;
    pattern = 8'd0; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      pattern[7-i] = cmd_ready;
      if (cmd_ready) n_acc++;
    end
    cmd_valid = 1'b0;
    check_val("tput_acc", n_acc, 32'd2);
    check_val("tput_ready_pattern", {24'd0, pattern}, {24'd0, 8'b1000_1000});

    // Reset asserted during EXEC aborts the command.
    wait_ready();
    cmd_valid = 1'b1; cmd_funct = 4'd3; cmd_rs1 = 3'd0; cmd_rd = 3'd1;
    cmd_use_imm = 1'b1; cmd_imm = 32'd100;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("abort_exec_op2", alu_op2, 32'd100);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_wbv", {31'd0, wb_valid}, 32'd0);
    check_val("abort_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    check_val("abort_op2_rst", alu_op2, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    check_val("abort_wbv_after", {31'd0, wb_valid}, 32'd0);
    do_cmd("rd_r1", 4'd0, 3'd1, 3'd0, 3'd2, 1'b1, 32'd0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b1);

`ifdef ALU_SEQ_ILLEGAL_EN
    do_cmd("ill9",  4'd9, 3'd0, 3'd0, 3'd5, 1'b1, 32'd77, 32'd0, 32'd77, 3'd1, 32'd0, 1'b0);
    do_cmd("rd_r5", 4'd0, 3'd5, 3'd0, 3'd6, 1'b1, 32'd0,  32'd0, 32'd0,  3'd0, 32'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter REG_AW, default 3: register-file address width, giving 2**REG_AW x 32-bit registers.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1: command present.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_funct, input, 4: operation code; 0-7 are legal, 8-15 are illegal.
REQ-007 SHALL have ports cmd_rs1, cmd_rs2 and cmd_rd, input, REG_AW each: source and destination register indices.
REQ-008 SHALL have port cmd_use_imm, input, 1: operand 2 comes from cmd_imm instead of rs2.
REQ-009 SHALL have port cmd_imm, input, 32: immediate operand.
REQ-010 SHALL have ports alu_op1 and alu_op2, output, 32 each: operands driven to the ALU.
REQ-011 SHALL have port alu_aluop, output, 3: ALU operation select.
REQ-012 SHALL have port alu_result, input, 32: combinational ALU result.
REQ-013 SHALL have ports wb_valid (output, 1), wb_rd (output, REG_AW) and wb_data (output, 32): one-cycle writeback report.
REQ-014 SHALL have port err, output, 1: one-cycle illegal-command pulse; present only with ALU_SEQ_ILLEGAL_EN.

Function
REQ-015 SHALL use the FSM IDLE -> READ -> EXEC -> WB -> IDLE, advancing one state per clk.
REQ-016 SHALL drive cmd_ready=1 only in IDLE.
REQ-017 SHALL capture funct, rs1, rs2, rd, use_imm and imm on acceptance; input changes after acceptance SHALL have no effect.
REQ-018 READ SHALL latch op1=RF[rs1] and op2 = use_imm ? imm : RF[rs2] into registers.
REQ-019 EXEC SHALL hold alu_op1, alu_op2 and alu_aluop stable from the latched values, and register alu_result at the end of the cycle.
REQ-020 In WB, wb_valid SHALL be 1, wb_rd SHALL be the latched rd, and wb_data SHALL be the registered result; RF[rd] SHALL be written at the same edge.
REQ-021 Latency from the acceptance edge to wb_valid high SHALL be 3 cycles; throughput SHALL be one command per 4 cycles.
REQ-022 funct[2:0] SHALL map to aluop as: 0 OR=000, 1 AND=001, 2 XOR=010, 3 ADD=011, 4 NOR=100, 5 NAND=101, 6 SLT=110 (unsigned), 7 SUB=111.
REQ-023 RF[0] SHALL read as 0; writes to index 0 SHALL be discarded, while wb_valid still pulses with wb_data = result.
REQ-024 When rd equals rs1 or rs2 of the next command, that command SHALL read the new value, since the write completes before its READ.
REQ-025 Outside EXEC, alu_op1 and alu_op2 SHALL hold their last latched values and alu_aluop SHALL hold its last value.
REQ-026 All arithmetic SHALL be 32-bit modulo; no overflow flag SHALL be generated.

Reset
REQ-027 While rst=1 at a clk edge, the FSM SHALL go to IDLE and cmd_ready, wb_valid and err SHALL be 0; wb_rd, wb_data, alu_op1, alu_op2 and alu_aluop SHALL be 0.
REQ-028 All RF entries SHALL reset to 0.
REQ-029 Reset mid-command SHALL abort it with no RF write and no wb_valid.

Configuration
REQ-030 With ALU_SEQ_ILLEGAL_EN defined, funct[3]=1 SHALL pulse err for one cycle in the WB slot, with no RF write and wb_valid=0; the same 4-cycle timing SHALL apply.
REQ-031 Without ALU_SEQ_ILLEGAL_EN, the err port SHALL be absent, funct[3] SHALL be ignored, and funct[2:0] SHALL decode normally.

Structure
REQ-032 The shared package SHALL hold the 3-bit aluop localparams (OR, AND, XOR, ADD, NOR, NAND, SLT, SUB), the 4-bit funct codes, and the FSM state encoding.
REQ-033 Decoding SHALL be done in a combinational sub-module alu_op_decode (funct -> aluop, illegal).

Verification
REQ-034 After reset, the bench SHALL issue ADD rd=1, imm=5 with rs1=0 -> wb_valid 3 cycles after acceptance, wb_rd=1, wb_data=5.
REQ-035 The bench SHALL issue SUB rd=2, rs1=1, imm=7 -> wb_data=0xFFFFFFFE, and RF[2] SHALL read back via a subsequent OR rd=3, rs1=2, imm=0 -> 0xFFFFFFFE.
REQ-036 The bench SHALL issue SLT with rs1=RF[1]=5 and imm=0xFFFFFFFF -> wb_data=1 (unsigned compare).
REQ-037 The bench SHALL hold cmd_valid high for 8 cycles -> exactly 2 acceptances, cmd_ready low for 3 cycles between them.
REQ-038 The bench SHALL issue ADD with rd=0 and imm=9 -> wb_valid=1, wb_data=9, and a subsequent read of RF[0] SHALL give 0.
REQ-039 The bench SHALL assert rst during EXEC -> no wb_valid, RF unchanged, cmd_ready=1 on the cycle after rst deasserts; with ALU_SEQ_ILLEGAL_EN, funct=9 SHALL produce err=1 for one cycle and wb_valid=0.
